// File: rtl/e_mdu.sv
// E-stage multiply/divide unit owning HI/LO; result commits MULT_CYCLES/DIV_CYCLES after start.
// Optional madd/maddu/msub/msubu family enabled by defining MDU_MADD_EN.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [31:0]   r_hi, r_lo, r_phi, r_plo;
    logic          w_is_mul, w_is_div, w_mul_signed, w_launch, w_commit;
    logic [63:0]   w_ma, w_mb, w_prod, w_res;
    logic          w_a_neg, w_b_neg;
    logic [31:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_q, w_r;

    always_comb begin
        w_is_mul     = (mdu_op == 4'd1) || (mdu_op == 4'd2);
        w_mul_signed = (mdu_op == 4'd1);
`ifdef MDU_MADD_EN
        if (mdu_op >= 4'd9 && mdu_op <= 4'd12) w_is_mul = 1'b1;
        if (mdu_op == 4'd9 || mdu_op == 4'd11) w_mul_signed = 1'b1;
`endif
        w_is_div = (mdu_op == 4'd3) || (mdu_op == 4'd4);
    end

    assign w_launch = start && (r_state == S_IDLE) && (w_is_mul || w_is_div);

    // 64x64 product of sign- or zero-extended operands; low 64 bits are exact for both
    assign w_ma   = {{32{w_mul_signed & a[31]}}, a};
    assign w_mb   = {{32{w_mul_signed & b[31]}}, b};
    assign w_prod = w_ma * w_mb;

    // Signed divide via magnitudes avoids the 0x80000000 / -1 overflow case
    assign w_a_neg = (mdu_op == 4'd3) & a[31];
    assign w_b_neg = (mdu_op == 4'd3) & b[31];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;
    assign w_q_mag = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag / w_b_mag;
    assign w_r_mag = (w_b_mag == 32'd0) ? 32'd0 : w_a_mag % w_b_mag;
    assign w_q     = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
    assign w_r     = w_a_neg ? -w_r_mag : w_r_mag;

    always_comb begin
        w_res = {r_hi, r_lo};
        case (mdu_op)
            4'd1, 4'd2: w_res = w_prod;
            4'd3, 4'd4: if (b != 32'd0) w_res = {w_r, w_q};
`ifdef MDU_MADD_EN
            4'd9, 4'd10:  w_res = {r_hi, r_lo} + w_prod;
            4'd11, 4'd12: w_res = {r_hi, r_lo} - w_prod;
`endif
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE: if (w_launch) begin
                w_state_nxt = S_BUSY;
                w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            S_BUSY: if (r_cnt == CW'(1)) begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_commit    = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - CW'(1);
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_launch) {r_phi, r_plo} <= w_res;
            if (w_commit) begin
                r_hi <= r_phi;
                r_lo <= r_plo;
            end else if (r_state == S_IDLE && !start) begin
                if (mdu_op == 4'd7) r_hi <= a;
                if (mdu_op == 4'd8) r_lo <= a;
            end
        end
    end

    assign busy    = (r_state == S_BUSY);
    assign hi      = r_hi;
    assign lo      = r_lo;
    assign mdu_out = (mdu_op == 4'd5) ? r_hi : (mdu_op == 4'd6) ? r_lo : 32'd0;
endmodule

// File: tb/tb_e_mdu.sv
// Randomized bench for e_mdu against a longint-arithmetic model of HI/LO and busy timing.
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset, start;
    logic [3:0]  mdu_op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo, mdu_out;

    localparam int MC = 5;
    localparam int DC = 10;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_launch(input logic [3:0] op);
`ifdef MDU_MADD_EN
        return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd12);
`else
        return (op >= 4'd1 && op <= 4'd4);
`endif
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] oh, input logic [31:0] ol);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, acc;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        acc = {oh, ol};
        case (op)
            4'd1: return 64'(sx * sy);
            4'd2: return ux * uy;
            4'd3: begin
                if (y == 32'd0) return acc;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            4'd4: begin
                if (y == 32'd0) return acc;
                return {x % y, x / y};
            end
            4'd9:  return acc + 64'(sx * sy);
            4'd10: return acc + ux * uy;
            4'd11: return acc - 64'(sx * sy);
            4'd12: return acc - ux * uy;
            default: return acc;
        endcase
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, ".busy"}, {63'd0, busy}, 64'd0);
        chk({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
        mdu_op = 4'd5; #1;
        chk({tag, ".mfhi"}, {32'd0, mdu_out}, {32'd0, m_hi});
        mdu_op = 4'd6; #1;
        chk({tag, ".mflo"}, {32'd0, mdu_out}, {32'd0, m_lo});
        mdu_op = 4'd0; #1;
        chk({tag, ".none"}, {32'd0, mdu_out}, 64'd0);
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input bit inj);
        logic [63:0] exp;
        int          n;
        if (is_launch(op)) begin
            @(negedge clk);
            start = 1'b1; mdu_op = op; a = x; b = y;
            exp = model(op, x, y, m_hi, m_lo);
            n = (op == 4'd3 || op == 4'd4) ? DC : MC;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                chk("busy_hi", {63'd0, busy}, 64'd1);
                chk("hold", {hi, lo}, {m_hi, m_lo});
                start = 1'b0; mdu_op = 4'd0; a = $urandom; b = $urandom;
                if (inj && i >= 1 && i <= n - 2) begin
                    case ($urandom_range(0, 2))
                        0: mdu_op = 4'd7;
                        1: mdu_op = 4'd8;
                        default: begin start = 1'b1; mdu_op = 4'd1; end
                    endcase
                end
            end
            @(negedge clk);
            {m_hi, m_lo} = exp;
            check_idle("op");
        end else if (op == 4'd7 || op == 4'd8) begin
            @(negedge clk);
            start = 1'b0; mdu_op = op; a = x; b = y;
            @(negedge clk);
            mdu_op = 4'd0;
            if (op == 4'd7) m_hi = x; else m_lo = x;
            check_idle("mt");
        end else begin
            @(negedge clk);
            start = 1'b1; mdu_op = op; a = x; b = y;
            @(negedge clk);
            start = 1'b0; mdu_op = 4'd0;
            check_idle("nolaunch");
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_idle("reset");

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd8, 32'h55, 32'd0, 1'b0);
        run_op(4'd4, 32'd7, 32'd0, 1'b0);
        chk("divu0_const", {32'd0, lo}, 64'h55);
        run_op(4'd7, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_const", {32'd0, hi}, 64'h1234_5678);
        run_op(4'd1, 32'd9, 32'd9, 1'b1);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(4'd7, 32'd0, 32'd0, 1'b0);
        run_op(4'd8, 32'd10, 32'd0, 1'b0);
        run_op(4'd9, 32'd3, 32'd4, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_const", {32'd0, lo}, 64'd22);
`else
        chk("madd_off_const", {32'd0, lo}, 64'd10);
`endif

        // Reset during the third busy cycle must abort without committing
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd1; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        chk("rst_busy1", {63'd0, busy}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check_idle("rst_mid");
        repeat (8) @(negedge clk);
        check_idle("rst_after");

        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 12));
            x  = $urandom;
            y  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
            run_op(op, x, y, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
